// File: rtl/io_bus_responder.sv
// Memory-mapped IO responder: PORTOUT/PORTIN registers, TX FIFO, STATUS. Optional IO_RESP_CHANGE_DETECT_EN adds PortIn change flag.
// Reads are combinational from registered state; a push to a full FIFO is dropped and flagged as overflow; pops follow TxValid && TxReady.
module io_bus_responder #(
  parameter logic [31:0] BASE_ADDR  = 32'h1001_0000,
  parameter int          FIFO_DEPTH = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] Address,
  input  logic [31:0] WriteData,
  input  logic        MemWrite,
  input  logic        MemRead,
  output logic [31:0] ReadData,
  input  logic [7:0]  PortIn,
  output logic [31:0] PortOut,
  output logic [31:0] TxData,
  output logic        TxValid,
  input  logic        TxReady
);

  localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);

  logic          sel;
  logic [1:0]    offset;
  logic          unused_addr;
  logic          wr_en;
  logic          push_req;
  logic          push;
  logic          pop;
  logic          full;
  logic          empty;
  logic          flag_clr;
  logic [31:0]   port_out;
  logic [7:0]    sync1;
  logic [7:0]    sync2;
  logic [PW-1:0] rd_ptr;
  logic [PW-1:0] wr_ptr;
  logic [CW-1:0] count;
  logic          overflow;
  logic          change;
  logic [31:0]   status;
  logic [31:0]   mem [FIFO_DEPTH];

  assign sel         = (Address[31:4] == BASE_ADDR[31:4]);
  assign offset      = Address[3:2];
  assign unused_addr = ^Address[1:0];

  assign wr_en    = MemWrite && sel;
  assign push_req = wr_en && (offset == 2'd2);
  assign flag_clr = wr_en && (offset == 2'd3);
  assign full     = (count == DEPTH_C);
  assign empty    = (count == '0);
  // Full is the pre-pop state: a push against a full FIFO drops even if a pop frees a slot this cycle.
  assign push     = push_req && !full;
  assign pop      = !empty && TxReady;

  always_ff @(posedge clk) begin
    if (push && !reset) mem[wr_ptr] <= WriteData;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      port_out <= '0;
      sync1    <= '0;
      sync2    <= '0;
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      sync1 <= PortIn;
      sync2 <= sync1;
      if (wr_en && (offset == 2'd0)) port_out <= WriteData;
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
      overflow <= (push_req && full) || (overflow && !flag_clr);
    end
  end

`ifdef IO_RESP_CHANGE_DETECT_EN
  logic [7:0] sync_prev;

  always_ff @(posedge clk) begin
    if (reset) begin
      sync_prev <= '0;
      change    <= 1'b0;
    end else begin
      sync_prev <= sync2;
      change    <= (sync2 != sync_prev) || (change && !flag_clr);
    end
  end
`else
  assign change = 1'b0;
`endif

  assign status  = {22'b0, change, 5'(count), 1'b0, overflow, empty, full};
  assign TxValid = !empty;
  assign TxData  = empty ? 32'h0 : mem[rd_ptr];
  assign PortOut = port_out;

  always_comb begin
    ReadData = 32'h0;
    if (MemRead && sel) begin
      case (offset)
        2'd0:    ReadData = port_out;
        2'd1:    ReadData = {24'b0, sync2};
        2'd3:    ReadData = status;
        default: ReadData = 32'h0;
      endcase
    end
  end

endmodule

// File: tb/tb_io_bus_responder.sv
// Bench for io_bus_responder: directed vector table, hand-written corner sequences, randomized run against a queue-based model.
module tb_io_bus_responder;

  localparam logic [31:0] BASE  = 32'h1001_0000;
  localparam int          DEPTH = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] Address;
  logic [31:0] WriteData;
  logic        MemWrite;
  logic        MemRead;
  logic [31:0] ReadData;
  logic [7:0]  PortIn;
  logic [31:0] PortOut;
  logic [31:0] TxData;
  logic        TxValid;
  logic        TxReady;

  always #5 clk = ~clk;

  io_bus_responder #(.BASE_ADDR(BASE), .FIFO_DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset), .Address(Address), .WriteData(WriteData),
    .MemWrite(MemWrite), .MemRead(MemRead), .ReadData(ReadData),
    .PortIn(PortIn), .PortOut(PortOut), .TxData(TxData),
    .TxValid(TxValid), .TxReady(TxReady)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic acc(input logic we, input logic re, input logic [31:0] a, input logic [31:0] d);
    MemWrite  = we;
    MemRead   = re;
    Address   = a;
    WriteData = d;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    acc(0, 0, 32'h0, 32'h0);
    TxReady = 1'b0;
    PortIn  = 8'h00;
    tick();
    tick();
    reset = 1'b0;
  endtask

  // Reads STATUS at once (combinational), without advancing the clock.
  task automatic peek_status(input string name, input logic [31:0] exp);
    acc(0, 1, BASE + 32'hC, 32'h0);
    #2;
    check(name, ReadData, exp);
  endtask

  typedef struct {
    logic        we;
    logic        re;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        txr;
    logic [31:0] exp_rd;
    logic        exp_txv;
    logic [31:0] exp_txd;
    logic [31:0] exp_po;
  } vec_t;

  function automatic vec_t v(input logic we, input logic re, input logic [31:0] addr,
                             input logic [31:0] wdata, input logic txr, input logic [31:0] exp_rd,
                             input logic exp_txv, input logic [31:0] exp_txd, input logic [31:0] exp_po);
    vec_t r;
    r.we = we; r.re = re; r.addr = addr; r.wdata = wdata; r.txr = txr;
    r.exp_rd = exp_rd; r.exp_txv = exp_txv; r.exp_txd = exp_txd; r.exp_po = exp_po;
    return r;
  endfunction

  // Reference model: FIFO as a queue, flags and registers as plain variables.
  logic [31:0] mq[$];
  logic        m_ovf, m_chg;
  logic [31:0] m_po;
  logic [7:0]  m_s1, m_sync, m_prev;

  function automatic logic tb_sel();
    return Address[31:4] == BASE[31:4];
  endfunction

  function automatic logic [31:0] m_status();
    logic [31:0] s;
    logic [4:0]  n;
    n    = 5'(mq.size());
    s    = 32'h0;
    s[0] = (mq.size() == DEPTH);
    s[1] = (mq.size() == 0);
    s[2] = m_ovf;
    s[8:4] = n;
    s[9] = m_chg;
    return s;
  endfunction

  function automatic logic [31:0] m_rd();
    if (!(MemRead && tb_sel())) return 32'h0;
    case (Address[3:2])
      2'd0:    return m_po;
      2'd1:    return {24'h0, m_sync};
      2'd3:    return m_status();
      default: return 32'h0;
    endcase
  endfunction

  task automatic m_reset();
    mq.delete();
    m_ovf = 0; m_chg = 0; m_po = 0; m_s1 = 0; m_sync = 0; m_prev = 0;
  endtask

  task automatic m_edge();
    logic wsel, push_req, was_full, clr, pop, chg_set;
    if (reset) begin
      m_reset();
    end else begin
      wsel     = MemWrite && tb_sel();
      push_req = wsel && (Address[3:2] == 2'd2);
      clr      = wsel && (Address[3:2] == 2'd3);
      was_full = (mq.size() == DEPTH);
      pop      = (mq.size() != 0) && TxReady;
`ifdef IO_RESP_CHANGE_DETECT_EN
      chg_set = (m_sync != m_prev);
`else
      chg_set = 1'b0;
`endif
      if (pop) void'(mq.pop_front());
      if (push_req && !was_full) mq.push_back(WriteData);
      m_ovf = (push_req && was_full) || (m_ovf && !clr);
      m_chg = chg_set || (m_chg && !clr);
      if (wsel && Address[3:2] == 2'd0) m_po = WriteData;
      m_prev = m_sync;
      m_sync = m_s1;
      m_s1   = PortIn;
    end
  endtask

  vec_t tbl[$];
  logic [31:0] chg_bit;

  initial begin
    reset = 1'b1;
    acc(0, 0, 32'h0, 32'h0);
    TxReady = 1'b0;
    PortIn  = 8'h00;
`ifdef IO_RESP_CHANGE_DETECT_EN
    chg_bit = 32'h200;
`else
    chg_bit = 32'h0;
`endif

    // we re addr wdata txr | exp ReadData, TxValid, TxData, PortOut (all before the row's edge)
    tbl.push_back(v(0, 1, BASE + 32'hC,  32'h0,         0, 32'h0000_0002, 0, 32'h0, 32'h0));
    tbl.push_back(v(1, 0, BASE + 32'h0,  32'hA5A5_0001, 0, 32'h0,         0, 32'h0, 32'h0));
    tbl.push_back(v(0, 1, BASE + 32'h0,  32'h0,         0, 32'hA5A5_0001, 0, 32'h0, 32'hA5A5_0001));
    tbl.push_back(v(0, 1, BASE + 32'h10, 32'h0,         0, 32'h0,         0, 32'h0, 32'hA5A5_0001));
    tbl.push_back(v(0, 1, BASE + 32'h3,  32'h0,         0, 32'hA5A5_0001, 0, 32'h0, 32'hA5A5_0001));
    tbl.push_back(v(0, 1, BASE + 32'h4,  32'h0,         0, 32'h0,         0, 32'h0, 32'hA5A5_0001));
    tbl.push_back(v(1, 0, BASE + 32'h8,  32'h1,         0, 32'h0,         0, 32'h0, 32'hA5A5_0001));
    tbl.push_back(v(1, 0, BASE + 32'h8,  32'h2,         0, 32'h0,         1, 32'h1, 32'hA5A5_0001));
    tbl.push_back(v(1, 0, BASE + 32'h8,  32'h3,         0, 32'h0,         1, 32'h1, 32'hA5A5_0001));
    tbl.push_back(v(1, 0, BASE + 32'h8,  32'h4,         0, 32'h0,         1, 32'h1, 32'hA5A5_0001));
    tbl.push_back(v(1, 0, BASE + 32'h8,  32'h5,         0, 32'h0,         1, 32'h1, 32'hA5A5_0001));
    tbl.push_back(v(0, 1, BASE + 32'hC,  32'h0,         0, 32'h0000_0045, 1, 32'h1, 32'hA5A5_0001));
    tbl.push_back(v(0, 1, BASE + 32'h8,  32'h0,         0, 32'h0,         1, 32'h1, 32'hA5A5_0001));
    tbl.push_back(v(1, 0, 32'h2001_000C, 32'h99,        0, 32'h0,         1, 32'h1, 32'hA5A5_0001));
    tbl.push_back(v(0, 1, BASE + 32'hC,  32'h0,         0, 32'h0000_0045, 1, 32'h1, 32'hA5A5_0001));
    tbl.push_back(v(0, 0, 32'h0,         32'h0,         1, 32'h0,         1, 32'h1, 32'hA5A5_0001));
    tbl.push_back(v(0, 0, 32'h0,         32'h0,         1, 32'h0,         1, 32'h2, 32'hA5A5_0001));
    tbl.push_back(v(0, 0, 32'h0,         32'h0,         1, 32'h0,         1, 32'h3, 32'hA5A5_0001));
    tbl.push_back(v(0, 0, 32'h0,         32'h0,         1, 32'h0,         1, 32'h4, 32'hA5A5_0001));
    tbl.push_back(v(0, 1, BASE + 32'hC,  32'h0,         1, 32'h0000_0006, 0, 32'h0, 32'hA5A5_0001));
    tbl.push_back(v(1, 0, BASE + 32'hC,  32'h1234,      0, 32'h0,         0, 32'h0, 32'hA5A5_0001));
    tbl.push_back(v(0, 1, BASE + 32'hC,  32'h0,         0, 32'h0000_0002, 0, 32'h0, 32'hA5A5_0001));

    do_reset();
    for (int i = 0; i < tbl.size(); i++) begin
      acc(tbl[i].we, tbl[i].re, tbl[i].addr, tbl[i].wdata);
      TxReady = tbl[i].txr;
      #3;
      check($sformatf("vec%0d_rd", i),  ReadData, tbl[i].exp_rd);
      check($sformatf("vec%0d_txv", i), {31'h0, TxValid}, {31'h0, tbl[i].exp_txv});
      check($sformatf("vec%0d_txd", i), TxData, tbl[i].exp_txd);
      check($sformatf("vec%0d_po", i),  PortOut, tbl[i].exp_po);
      tick();
    end

    // Full FIFO, pop and push in the same cycle: push dropped, overflow set, count 3.
    do_reset();
    for (int i = 1; i <= DEPTH; i++) begin
      acc(1, 0, BASE + 32'h8, 32'(i * 16));
      tick();
    end
    TxReady = 1'b1;
    acc(1, 0, BASE + 32'h8, 32'hDEAD);
    #2;
    check("full_pop_head", TxData, 32'h10);
    tick();
    TxReady = 1'b0;
    peek_status("full_pop_status", 32'h0000_0034);
    check("full_pop_head2", TxData, 32'h20);
    tick();
    acc(1, 0, BASE + 32'hC, 32'h0);
    tick();
    peek_status("ovf_clear", 32'h0000_0030);
    TxReady = 1'b0;
    tick();
    check("stall_hold", TxData, 32'h20);
    acc(0, 0, 32'h0, 32'h0);
    TxReady = 1'b1;
    tick(); check("drain_30", TxData, 32'h30);
    tick(); check("drain_40", TxData, 32'h40);
    tick(); check("drain_empty", {31'h0, TxValid}, 32'h0);

    // PortIn synchronizer latency and change flag.
    do_reset();
    tick();
    PortIn = 8'h3C;
    acc(0, 1, BASE + 32'h4, 32'h0);
    #2; check("portin_edge0", ReadData, 32'h0);
    tick(); check("portin_edge1", ReadData, 32'h0);
    tick(); check("portin_edge2", ReadData, 32'h3C);
    tick();
    tick();
    peek_status("change_set", 32'h2 | chg_bit);
    tick();
    peek_status("change_sticky", 32'h2 | chg_bit);
    acc(1, 0, BASE + 32'hC, 32'h0);
    tick();
    peek_status("change_clr", 32'h2);

    // Reset during a pop cycle discards everything.
    do_reset();
    acc(1, 0, BASE + 32'h0, 32'h77);
    tick();
    acc(1, 0, BASE + 32'h8, 32'hA);
    tick();
    acc(1, 0, BASE + 32'h8, 32'hB);
    tick();
    acc(1, 0, BASE + 32'h8, 32'hC);
    TxReady = 1'b1;
    reset   = 1'b1;
    tick();
    reset   = 1'b0;
    TxReady = 1'b0;
    acc(0, 0, 32'h0, 32'h0);
    #2;
    check("rst_txv", {31'h0, TxValid}, 32'h0);
    check("rst_txd", TxData, 32'h0);
    check("rst_po", PortOut, 32'h0);
    peek_status("rst_status", 32'h0000_0002);

    // Randomized run against the model.
    do_reset();
    m_reset();
    for (int c = 0; c < 3000; c++) begin
      int r;
      reset    = ($urandom_range(0, 199) == 0);
      MemWrite = ($urandom_range(0, 2) != 0);
      MemRead  = ($urandom_range(0, 1) != 0);
      r = $urandom_range(0, 11);
      if (r < 10)
        Address = BASE | {26'h0, (r < 5) ? 2'd2 : 2'($urandom_range(0, 3)), 2'($urandom_range(0, 3))};
      else
        Address = BASE ^ (32'h10 << $urandom_range(0, 27));
      WriteData = $urandom;
      TxReady   = ($urandom_range(0, 2) == 0);
      if ($urandom_range(0, 7) == 0) PortIn = 8'($urandom);
      #3;
      check("rnd_rd",  ReadData, m_rd());
      check("rnd_txv", {31'h0, TxValid}, {31'h0, mq.size() != 0});
      check("rnd_txd", TxData, (mq.size() != 0) ? mq[0] : 32'h0);
      check("rnd_po",  PortOut, m_po);
      m_edge();
      tick();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
